imem_boot_arbiter: RTL and testbench

- Controller that owns the single port of the instruction memory (2048 x 32-bit words, word-addressed, 1-cycle synchronous read).
- After reset, runs a boot-load phase: a loader stream writes the program from word 0 upward while the CPU is stalled.
- In run phase, arbitrates reads between CPU instruction fetch (priority) and a debug read port.
- Sits between the PC/fetch stage, the program loader, and the IMEM array.

---
 rtl/imem_boot_arbiter.sv | 156 +++++++++++++++
 tb/tb_imem_boot_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_arbiter.sv
// imem_boot_arbiter: owner of the single instruction-memory port.
// After reset a loader stream fills IMEM from word 0 while the CPU is stalled.
// In RUN, CPU fetch and a debug read port share the port, with fetch having priority.
// Optional debug starvation guard: define IMEM_BOOT_ARBITER_STARVE_GUARD_EN.
module imem_boot_arbiter #(
    parameter int unsigned AW         = 11,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          reload,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_valid,
    output logic [DW-1:0] fetch_instr,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_data,
    output logic          boot_done,
    output logic [AW:0]   words_loaded
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = $clog2(STARVE_LIM + 2);

`ifdef IMEM_BOOT_ARBITER_STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    state_t          state, state_next;
    logic [AW-1:0]   ptr, ptr_next;
    logic [AW:0]     words_next;
    logic            fetch_grant;
    logic            dbg_grant;
    logic            force_dbg;
    logic            last_slot;
    logic [CW-1:0]   wait_cnt;
    logic [DW-1:0]   instr_q;
    logic [DW-1:0]   dbg_q;

    assign last_slot = (ptr == AW'(DEPTH - 1));

    // The wait counter saturates one past the limit; that value forces the debug slot.
    assign force_dbg = GUARD_EN && (state == RUN) && dbg_req
                       && (wait_cnt == CW'(STARVE_LIM + 1));

    // Read data is shown directly in the valid cycle, otherwise the last captured word is held.
    assign fetch_instr = fetch_valid ? mem_rdata : instr_q;
    assign dbg_data    = dbg_ack ? mem_rdata : dbg_q;

    // Next-state, memory port drive and arbitration.
    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        words_next  = words_loaded;
        fetch_grant = 1'b0;
        dbg_grant   = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = ptr;
        mem_wdata   = ld_data;
        ld_ready    = 1'b0;
        boot_done   = 1'b0;
        cpu_stall   = 1'b1;
        case (state)
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid && !reset) begin
                    mem_we     = 1'b1;
                    words_next = words_loaded + (AW+1)'(1);
                    ptr_next   = last_slot ? ptr : ptr + AW'(1);
                    if (ld_last || last_slot) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                boot_done = 1'b1;
                cpu_stall = force_dbg;
                mem_addr  = fetch_addr;
                if (force_dbg) begin
                    dbg_grant = 1'b1;
                end else if (fetch_req) begin
                    fetch_grant = 1'b1;
                end else if (dbg_req && !dbg_ack) begin
                    dbg_grant = 1'b1;
                end
                if (dbg_grant) begin
                    mem_addr = dbg_addr;
                end
                if (reload) begin
                    state_next = LOAD;
                    ptr_next   = '0;
                    words_next = '0;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // State, pointer, read-response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD;
            ptr          <= '0;
            words_loaded <= '0;
            fetch_valid  <= 1'b0;
            dbg_ack      <= 1'b0;
            instr_q      <= '0;
            dbg_q        <= '0;
        end else begin
            state        <= state_next;
            ptr          <= ptr_next;
            words_loaded <= words_next;
            fetch_valid  <= fetch_grant;
            dbg_ack      <= dbg_grant;
            if (fetch_valid) begin
                instr_q <= mem_rdata;
            end
            if (dbg_ack) begin
                dbg_q <= mem_rdata;
            end
        end
    end

    // Counts cycles a debug request waits ungranted in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != RUN || !dbg_req || dbg_grant || dbg_ack) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CW'(STARVE_LIM + 1)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Bench for imem_boot_arbiter: IMEM model, reference memory image and
// fetch/debug scoreboards checked as read responses appear.
module tb_imem_boot_arbiter;

    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2048;
    localparam int          LIM   = 4;

`ifdef IMEM_BOOT_ARBITER_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          reload;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_valid;
    logic [DW-1:0] fetch_instr;
    logic          cpu_stall;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_ack;
    logic [DW-1:0] dbg_data;
    logic          boot_done;
    logic [AW:0]   words_loaded;

    imem_boot_arbiter dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .reload(reload),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
        .boot_done(boot_done), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // IMEM array: write on mem_we, 1-cycle synchronous read.
    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int            n_checks = 0;
    int            n_errors = 0;
    int            dbg_acks = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] dq[$];
    bit            prev_fetch;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard pop on each read response.
    always @(negedge clk) begin
        if (fetch_valid) begin
            if (fq.size() == 0) check("fetch_extra", 32'(fetch_valid), 32'd0);
            else check("fetch_instr", fetch_instr, fq.pop_front());
        end
        if (dbg_ack) begin
            dbg_acks++;
            if (dq.size() == 0) check("dbg_extra", 32'(dbg_ack), 32'd0);
            else check("dbg_data", dbg_data, dq.pop_front());
        end
    end

    task automatic check_reset_vals();
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_cpu_stall", 32'(cpu_stall), 32'd1);
        check("rst_boot_done", 32'(boot_done), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        check("rst_fetch_instr", fetch_instr, 32'd0);
        check("rst_dbg_data", dbg_data, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        ld_valid = 0; ld_last = 0; fetch_req = 0; dbg_req = 0; reload = 0;
        @(negedge clk);
        check("fetch_valid", 32'(fetch_valid), 32'(prev_fetch));
        prev_fetch = 0;
    endtask

    task automatic load_word(input int addr, input logic [31:0] data, input bit last, input bit rl);
        @(posedge clk); #1;
        ld_valid = 1; ld_data = data; ld_last = last; reload = rl;
        @(negedge clk);
        check("ld_mem_we", 32'(mem_we), 32'd1);
        check("ld_mem_addr", 32'(mem_addr), 32'(addr));
        check("ld_mem_wdata", mem_wdata, data);
        check("ld_ready", 32'(ld_ready), 32'd1);
        check("ld_cpu_stall", 32'(cpu_stall), 32'd1);
        check("ld_fetch_valid", 32'(fetch_valid), 32'(prev_fetch));
        prev_fetch = 0;
        ref_mem[addr] = data;
    endtask

    task automatic fetch(input int addr);
        @(posedge clk); #1;
        fetch_req = 1; fetch_addr = AW'(addr); fq.push_back(ref_mem[addr]);
        @(negedge clk);
        check("f_mem_addr", 32'(mem_addr), 32'(addr));
        check("f_fetch_valid", 32'(fetch_valid), 32'(prev_fetch));
        check("f_cpu_stall", 32'(cpu_stall), 32'd0);
        prev_fetch = 1;
    endtask

    initial begin
        int lat;
        int a0;
        bit forced;
        reset = 1; ld_valid = 0; ld_data = '0; ld_last = 0; reload = 0;
        fetch_req = 0; fetch_addr = '0; dbg_req = 0; dbg_addr = '0; prev_fetch = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();

        // Boot load of 3 words; fetch/debug requests are ignored while loading.
        @(posedge clk); #1;
        reset = 0; fetch_req = 1; dbg_req = 1;
        load_word(0, 32'h24080001, 0, 0);
        load_word(1, 32'h24090002, 0, 0);
        load_word(2, 32'h01095020, 1, 0);
        idle();
        check("boot_done", 32'(boot_done), 32'd1);
        check("words_3", 32'(words_loaded), 32'd3);
        check("run_stall", 32'(cpu_stall), 32'd0);
        check("run_ld_ready", 32'(ld_ready), 32'd0);
        check("load_no_ack", 32'(dbg_acks), 32'd0);

        // Single and back-to-back fetches.
        fetch(1); idle();
        fetch(0); fetch(1); fetch(2); idle(); idle();
        check("instr_hold", fetch_instr, 32'h01095020);

        // Debug read with fetch idle.
        a0 = dbg_acks;
        @(posedge clk); #1;
        dbg_req = 1; dbg_addr = AW'(2); dq.push_back(ref_mem[2]);
        lat = -1;
        for (int i = 0; i < 8 && lat < 0; i++) begin
            @(negedge clk);
            if (dbg_ack) lat = i;
        end
        check("dbg_lat", 32'(lat), 32'd1);
        idle(); idle();
        check("dbg_once", 32'(dbg_acks - a0), 32'd1);
        check("dbg_hold", dbg_data, 32'h01095020);

        // Fetch held high with a pending debug request.
        a0 = dbg_acks;
        for (int i = 0; i < 20; i++) begin
            forced = GUARD && (i == LIM + 1);
            @(posedge clk); #1;
            fetch_req = 1; fetch_addr = AW'(i % 3);
            dbg_req = !(GUARD && i > LIM + 2); dbg_addr = AW'(1);
            if (forced) dq.push_back(ref_mem[1]);
            else fq.push_back(ref_mem[i % 3]);
            @(negedge clk);
            check("starve_stall", 32'(cpu_stall), 32'(forced));
            check("starve_ack", 32'(dbg_ack), 32'(GUARD && i == LIM + 2));
            check("starve_fv", 32'(fetch_valid), 32'(prev_fetch));
            prev_fetch = !forced;
        end
        idle(); idle();
        check("starve_acks", 32'(dbg_acks - a0), GUARD ? 32'd1 : 32'd0);

        // Reload with a fetch in the same cycle.
        @(posedge clk); #1;
        reload = 1; fetch_req = 1; fetch_addr = AW'(2); fq.push_back(ref_mem[2]);
        @(negedge clk);
        check("rl_still_run", 32'(boot_done), 32'd1);
        prev_fetch = 1;
        idle();
        check("rl_boot_done", 32'(boot_done), 32'd0);
        check("rl_stall", 32'(cpu_stall), 32'd1);
        check("rl_ld_ready", 32'(ld_ready), 32'd1);
        check("rl_words", 32'(words_loaded), 32'd0);
        check("rl_ptr", 32'(mem_addr), 32'd0);

        // Full-depth load without ld_last; reload pulse mid-load is ignored.
        for (int i = 0; i < int'(DEPTH); i++) load_word(i, $urandom, 0, i == 10);
        idle();
        check("full_boot_done", 32'(boot_done), 32'd1);
        check("full_ld_ready", 32'(ld_ready), 32'd0);
        check("full_words", 32'(words_loaded), 32'd2048);
        fetch(0); fetch(2047); fetch(1000); idle();

        @(posedge clk); #1;
        reload = 1;
        @(negedge clk);
        idle();
        check("rl2_stall", 32'(cpu_stall), 32'd1);
        check("rl2_boot_done", 32'(boot_done), 32'd0);
        check("rl2_ptr", 32'(mem_addr), 32'd0);
        check("rl2_words", 32'(words_loaded), 32'd0);

        // Reset after 5 of 10 words, then a fresh load from address 0.
        for (int i = 0; i < 5; i++) load_word(i, 32'hA0000000 + 32'(i), 0, 0);
        @(posedge clk); #1;
        reset = 1; ld_valid = 1; ld_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        reset = 0; ld_valid = 0;
        @(negedge clk);
        check_reset_vals();
        prev_fetch = 0;
        load_word(0, 32'hB0000000, 0, 0);
        load_word(1, 32'hB0000001, 0, 0);
        load_word(2, 32'hB0000002, 1, 0);
        idle();
        check("rst2_words", 32'(words_loaded), 32'd3);
        for (int i = 0; i < 6; i++) fetch(i);
        idle(); idle();

        check("fq_empty", 32'(fq.size()), 32'd0);
        check("dq_empty", 32'(dq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
